// File: rtl/task_parser.sv
// Task front-end: parses opcode/length frames from an Avalon-ST sink, dispatches OUT tasks, returns one response word per task.
// Optional TASK_PARSER_ECHO_EN: response word carries {opcode[15:0], code[15:0]} instead of the bare code.
module task_parser #(
    parameter logic [31:0] OPCODE_OUT    = 32'h1,
    parameter logic [31:0] MAX_LEN_BYTES = 32'd64,
    parameter logic [31:0] WORD_TIMEOUT  = 32'd1000,
    parameter logic [31:0] RESP_TIMEOUT  = 32'd200000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        asi_task_ready,
    input  logic        asi_task_valid,
    input  logic [31:0] asi_task_data,
    output logic        task_valid,
    output logic [31:0] len_bytes,
    output logic [31:0] out_strobe,
    input  logic        resp_valid,
    input  logic [31:0] resp,
    input  logic        aso_resp_ready,
    output logic        aso_resp_valid,
    output logic [31:0] aso_resp_data
);

    // Mirrors task_icd_pkg
    localparam logic [31:0] HEADER_WORDS   = 32'd2;
    localparam logic [31:0] TASK_VALID     = 32'h0000_00A0;
    localparam logic [31:0] HEADER_INVALID = 32'h0000_00E1;
    localparam logic [31:0] EXE_ERROR      = 32'h0000_00E2;

    typedef enum logic [2:0] {
        HDR_OP, HDR_LEN, PAYLOAD, DRAIN, DISPATCH, WAIT_RESP, SEND_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] opcode_q, opcode_d;
    logic [31:0] len_q, len_d;
    logic [31:0] words_q, words_d;
    logic [31:0] strobe_q, strobe_d;
    logic        first_q, first_d;
    logic [31:0] idle_q, idle_d;
    logic [31:0] resp_cnt_q, resp_cnt_d;
    logic [31:0] code_q, code_d;
    logic [31:0] len_out_q, len_out_d;
    logic [31:0] strobe_out_q, strobe_out_d;
    logic        aso_valid_q, aso_valid_d;
    logic [31:0] aso_data_q, aso_data_d;

    logic        xfer;
    logic        len_bad;
    logic [31:0] payload_words;
    logic [31:0] resp_word;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign asi_task_ready = (state_q == HDR_OP) || (state_q == HDR_LEN) ||
                            (state_q == PAYLOAD) || (state_q == DRAIN);
    assign xfer           = asi_task_valid & asi_task_ready;
    assign len_bad        = (asi_task_data[1:0] != 2'b00) || (asi_task_data < 32'd8) ||
                            (asi_task_data > MAX_LEN_BYTES);
    assign payload_words  = {2'b00, asi_task_data[31:2]} - HEADER_WORDS;

`ifdef TASK_PARSER_ECHO_EN
    assign resp_word = {opcode_q[15:0], code_q[15:0]};
`else
    assign resp_word = code_q;
`endif

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        len_d        = len_q;
        words_d      = words_q;
        strobe_d     = strobe_q;
        first_d      = first_q;
        idle_d       = idle_q;
        resp_cnt_d   = resp_cnt_q;
        code_d       = code_q;
        len_out_d    = len_out_q;
        strobe_out_d = strobe_out_q;
        aso_valid_d  = aso_valid_q;
        aso_data_d   = aso_data_q;

        unique case (state_q)
            HDR_OP: begin
                idle_d = '0;
                if (xfer) begin
                    opcode_d = asi_task_data;
                    state_d  = HDR_LEN;
                end
            end
            HDR_LEN: begin
                if (xfer) begin
                    idle_d = '0;
                    len_d  = asi_task_data;
                    if (len_bad) begin
                        code_d  = HEADER_INVALID;
                        state_d = SEND_RESP;
                    end else if (payload_words == '0) begin
                        if (opcode_q == OPCODE_OUT) begin
                            len_out_d    = asi_task_data;
                            strobe_out_d = '0;
                            state_d      = DISPATCH;
                        end else begin
                            code_d  = HEADER_INVALID;
                            state_d = SEND_RESP;
                        end
                    end else begin
                        words_d = payload_words;
                        first_d = 1'b1;
                        state_d = (opcode_q == OPCODE_OUT) ? PAYLOAD : DRAIN;
                    end
                end else if (sat_inc(idle_q) >= WORD_TIMEOUT) begin
                    code_d  = EXE_ERROR;
                    state_d = SEND_RESP;
                end else begin
                    idle_d = sat_inc(idle_q);
                end
            end
            PAYLOAD, DRAIN: begin
                if (xfer) begin
                    idle_d  = '0;
                    first_d = 1'b0;
                    words_d = words_q - 32'd1;
                    if (first_q) begin
                        strobe_d = asi_task_data;
                    end
                    if (words_q == 32'd1) begin
                        if (state_q == PAYLOAD) begin
                            len_out_d    = len_q;
                            strobe_out_d = first_q ? asi_task_data : strobe_q;
                            state_d      = DISPATCH;
                        end else begin
                            code_d  = HEADER_INVALID;
                            state_d = SEND_RESP;
                        end
                    end
                end else if (sat_inc(idle_q) >= WORD_TIMEOUT) begin
                    code_d  = EXE_ERROR;
                    state_d = SEND_RESP;
                end else begin
                    idle_d = sat_inc(idle_q);
                end
            end
            DISPATCH: begin
                resp_cnt_d = '0;
                state_d    = WAIT_RESP;
            end
            WAIT_RESP: begin
                // A response arriving on the timeout cycle still wins
                if (resp_valid) begin
                    code_d  = resp;
                    state_d = SEND_RESP;
                end else if (sat_inc(resp_cnt_q) >= RESP_TIMEOUT) begin
                    code_d  = EXE_ERROR;
                    state_d = SEND_RESP;
                end else begin
                    resp_cnt_d = sat_inc(resp_cnt_q);
                end
            end
            SEND_RESP: begin
                if (!aso_valid_q) begin
                    aso_valid_d = 1'b1;
                    aso_data_d  = resp_word;
                end else if (aso_resp_ready) begin
                    aso_valid_d = 1'b0;
                    state_d     = HDR_OP;
                end
            end
            default: state_d = HDR_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HDR_OP;
            opcode_q     <= '0;
            len_q        <= '0;
            words_q      <= '0;
            strobe_q     <= '0;
            first_q      <= 1'b0;
            idle_q       <= '0;
            resp_cnt_q   <= '0;
            code_q       <= '0;
            len_out_q    <= '0;
            strobe_out_q <= '0;
            aso_valid_q  <= 1'b0;
            aso_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            len_q        <= len_d;
            words_q      <= words_d;
            strobe_q     <= strobe_d;
            first_q      <= first_d;
            idle_q       <= idle_d;
            resp_cnt_q   <= resp_cnt_d;
            code_q       <= code_d;
            len_out_q    <= len_out_d;
            strobe_out_q <= strobe_out_d;
            aso_valid_q  <= aso_valid_d;
            aso_data_q   <= aso_data_d;
        end
    end

    assign task_valid     = (state_q == DISPATCH);
    assign len_bytes      = len_out_q;
    assign out_strobe     = strobe_out_q;
    assign aso_resp_valid = aso_valid_q;
    assign aso_resp_data  = aso_data_q;

endmodule

// File: tb/tb_task_parser.sv
// Directed self-checking bench for task_parser; response timeout shortened to keep runtime small.
module tb_task_parser;

    localparam logic [31:0] TASK_VALID     = 32'h0000_00A0;
    localparam logic [31:0] HEADER_INVALID = 32'h0000_00E1;
    localparam logic [31:0] EXE_ERROR      = 32'h0000_00E2;
    localparam int          RESP_TO        = 500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        asi_task_valid = 1'b0;
    logic [31:0] asi_task_data = '0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp = '0;
    logic        aso_resp_ready = 1'b1;
    logic        asi_task_ready;
    logic        task_valid;
    logic [31:0] len_bytes;
    logic [31:0] out_strobe;
    logic        aso_resp_valid;
    logic [31:0] aso_resp_data;

    int tests_run    = 0;
    int tests_failed = 0;

    int          tv_count  = 0;
    logic [31:0] tv_len    = '0;
    logic [31:0] tv_strobe = '0;
    int          rsp_count = 0;
    logic [31:0] rsp_last  = '0;

    logic        model_en   = 1'b1;
    logic [31:0] model_resp = TASK_VALID;
    int          model_cnt  = 0;

    task_parser #(.RESP_TIMEOUT(RESP_TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .asi_task_ready (asi_task_ready),
        .asi_task_valid (asi_task_valid),
        .asi_task_data  (asi_task_data),
        .task_valid     (task_valid),
        .len_bytes      (len_bytes),
        .out_strobe     (out_strobe),
        .resp_valid     (resp_valid),
        .resp           (resp),
        .aso_resp_ready (aso_resp_ready),
        .aso_resp_valid (aso_resp_valid),
        .aso_resp_data  (aso_resp_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (task_valid) begin
            tv_count++;
            tv_len    = len_bytes;
            tv_strobe = out_strobe;
        end
        if (aso_resp_valid && aso_resp_ready) begin
            rsp_count++;
            rsp_last = aso_resp_data;
        end
    end

    // out_cmd model: answers three cycles after the dispatch strobe
    always @(negedge clk) begin
        resp_valid = 1'b0;
        if (task_valid && model_en) begin
            model_cnt = 3;
        end else if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) begin
                resp_valid = 1'b1;
                resp       = model_resp;
            end
        end
    end

    function automatic logic [31:0] exp_word(input logic [31:0] op, input logic [31:0] code);
`ifdef TASK_PARSER_ECHO_EN
        return {op[15:0], code[15:0]};
`else
        return code;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d);
        int n = 0;
        asi_task_valid = 1'b1;
        asi_task_data  = d;
        while (!asi_task_ready && n < 2000) begin
            step();
            n++;
        end
        tests_run++;
        if (n >= 2000) begin
            tests_failed++;
            $display("FAIL send_word: ready never seen for word %h (waited %0d, need <2000)", d, n);
        end else begin
            step();
        end
        asi_task_valid = 1'b0;
    endtask

    task automatic wait_resp(input int limit, output int cycles);
        int start = rsp_count;
        cycles = 0;
        while (rsp_count == start && cycles < limit) begin
            step();
            cycles++;
        end
        tests_run++;
        if (rsp_count == start) begin
            tests_failed++;
            $display("FAIL wait_resp: no response within %0d cycles (got %0d responses, need %0d)",
                     limit, rsp_count - start, 1);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        tests_run++;
        if (got < lo || got > hi) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic test_reset();
        check_int ("reset_ready",      int'(asi_task_ready), 1);
        check_int ("reset_task_valid", int'(task_valid), 0);
        check_int ("reset_aso_valid",  int'(aso_resp_valid), 0);
        check_word("reset_len",        len_bytes, 32'h0);
        check_word("reset_strobe",     out_strobe, 32'h0);
        check_word("reset_aso_data",   aso_resp_data, 32'h0);
    endtask

    task automatic test_out_task();
        int tv0 = tv_count;
        int rc0 = rsp_count;
        int cyc;
        send_word(32'd1);
        send_word(32'd12);
        send_word(32'd5);
        check_int("busy_ready_low", int'(asi_task_ready), 0);
        wait_resp(100, cyc);
        check_int ("out_tv_count", tv_count - tv0, 1);
        check_word("out_len",      tv_len, 32'd12);
        check_word("out_strobe",   tv_strobe, 32'd5);
        check_word("out_resp",     rsp_last, exp_word(32'd1, TASK_VALID));
        step();
        check_int ("out_rsp_count", rsp_count - rc0, 1);
    endtask

    task automatic test_drain();
        int tv0 = tv_count;
        int cyc;
        send_word(32'd7);
        send_word(32'd16);
        send_word(32'h0000_000A);
        send_word(32'h0000_000B);
        wait_resp(50, cyc);
        check_int ("drain_no_tv", tv_count - tv0, 0);
        check_word("drain_resp",  rsp_last, exp_word(32'd7, HEADER_INVALID));
        send_word(32'd1);
        send_word(32'd12);
        send_word(32'd5);
        wait_resp(100, cyc);
        check_word("after_drain_resp",   rsp_last, exp_word(32'd1, TASK_VALID));
        check_word("after_drain_strobe", tv_strobe, 32'd5);
    endtask

    task automatic test_bad_len();
        int tv0 = tv_count;
        int cyc;
        send_word(32'd1);
        send_word(32'd10);
        wait_resp(20, cyc);
        check_range("len10_latency", cyc, 1, 4);
        check_word ("len10_resp", rsp_last, exp_word(32'd1, HEADER_INVALID));
        send_word(32'd1);
        send_word(32'd100);
        wait_resp(20, cyc);
        check_range("len100_latency", cyc, 1, 4);
        check_word ("len100_resp", rsp_last, exp_word(32'd1, HEADER_INVALID));
        send_word(32'd1);
        send_word(32'd68);
        wait_resp(20, cyc);
        check_word ("len68_resp", rsp_last, exp_word(32'd1, HEADER_INVALID));
        check_int  ("bad_len_no_tv", tv_count - tv0, 0);
        // next word after a rejected header is a fresh opcode
        send_word(32'd1);
        send_word(32'd12);
        send_word(32'd9);
        wait_resp(100, cyc);
        check_word("post_bad_strobe", tv_strobe, 32'd9);
        check_word("post_bad_resp",   rsp_last, exp_word(32'd1, TASK_VALID));
    endtask

    task automatic test_len_edges();
        int tv0;
        int cyc;
        send_word(32'd7);
        send_word(32'd8);
        wait_resp(20, cyc);
        check_word("len8_unknown_resp", rsp_last, exp_word(32'd7, HEADER_INVALID));
        tv0 = tv_count;
        send_word(32'd1);
        send_word(32'd8);
        wait_resp(100, cyc);
        check_int ("len8_out_tv",     tv_count - tv0, 1);
        check_word("len8_out_strobe", tv_strobe, 32'h0);
        check_word("len8_out_len",    tv_len, 32'd8);
        send_word(32'd1);
        send_word(32'd64);
        for (int i = 0; i < 14; i++) begin
            send_word(32'h100 + 32'(i));
        end
        wait_resp(100, cyc);
        check_word("len64_strobe", tv_strobe, 32'h100);
        check_word("len64_len",    tv_len, 32'd64);
        check_word("len64_resp",   rsp_last, exp_word(32'd1, TASK_VALID));
    endtask

    task automatic test_word_timeout();
        int tv0 = tv_count;
        int cyc;
        send_word(32'd1);
        send_word(32'd12);
        wait_resp(1200, cyc);
        check_range("word_to_latency", cyc, 980, 1020);
        check_word ("word_to_resp",  rsp_last, exp_word(32'd1, EXE_ERROR));
        check_int  ("word_to_no_tv", tv_count - tv0, 0);
    endtask

    task automatic test_resp_timeout();
        int tv0 = tv_count;
        int cyc;
        model_en = 1'b0;
        send_word(32'd1);
        send_word(32'd12);
        send_word(32'd5);
        wait_resp(RESP_TO + 100, cyc);
        check_range("resp_to_latency", cyc, RESP_TO - 10, RESP_TO + 20);
        check_word ("resp_to_resp", rsp_last, exp_word(32'd1, EXE_ERROR));
        check_int  ("resp_to_tv",   tv_count - tv0, 1);
        model_en = 1'b1;
    endtask

    task automatic test_backpressure();
        int          rc0 = rsp_count;
        int          n = 0;
        int          unstable = 0;
        int          cyc;
        logic [31:0] held;
        aso_resp_ready = 1'b0;
        model_resp     = 32'h0000_1234;
        send_word(32'd1);
        send_word(32'd12);
        send_word(32'd5);
        while (!aso_resp_valid && n < 100) begin
            step();
            n++;
        end
        check_int("bp_valid_seen", int'(aso_resp_valid), 1);
        held = aso_resp_data;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!aso_resp_valid || aso_resp_data !== held) unstable++;
        end
        check_int ("bp_stable",        unstable, 0);
        check_word("bp_held_data",     held, exp_word(32'd1, 32'h0000_1234));
        check_int ("bp_no_early_xfer", rsp_count - rc0, 0);
        aso_resp_ready = 1'b1;
        wait_resp(10, cyc);
        step();
        step();
        check_int ("bp_single_xfer", rsp_count - rc0, 1);
        check_int ("bp_valid_drop",  int'(aso_resp_valid), 0);
        model_resp = TASK_VALID;
    endtask

    task automatic test_reset_mid();
        int tv0;
        int rc0;
        int cyc;
        send_word(32'd1);
        send_word(32'd16);
        send_word(32'd3);
        tv0 = tv_count;
        rc0 = rsp_count;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_word("mid_rst_len",       len_bytes, 32'h0);
        check_word("mid_rst_strobe",    out_strobe, 32'h0);
        check_word("mid_rst_aso_data",  aso_resp_data, 32'h0);
        check_int ("mid_rst_aso_valid", int'(aso_resp_valid), 0);
        check_int ("mid_rst_tv",        int'(task_valid), 0);
        for (int i = 0; i < 20; i++) step();
        check_int("mid_rst_no_tv",   tv_count - tv0, 0);
        check_int("mid_rst_no_resp", rsp_count - rc0, 0);
        send_word(32'd1);
        send_word(32'd12);
        send_word(32'd3);
        wait_resp(100, cyc);
        check_word("mid_rst_fresh_strobe", tv_strobe, 32'd3);
        check_word("mid_rst_fresh_resp",   rsp_last, exp_word(32'd1, TASK_VALID));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_out_task();
        test_drain();
        test_bad_len();
        test_len_edges();
        test_word_timeout();
        test_resp_timeout();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
